// File: rtl/seq_pattern_detector.sv
// Serial bit-pattern detector with per-bit don't-care mask, overlap/non-overlap
// modes, registered match pulse, held match level and a saturating match counter.
module seq_pattern_detector #(
    parameter int PAT_W = 3,
    parameter int CNT_W = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         sample_en,
    input  logic                         din,
    input  logic [PAT_W-1:0]             pattern,
    input  logic [PAT_W-1:0]             mask,
    input  logic                         overlap,
    input  logic                         load,
    input  logic                         count_clr,
    output logic                         match,
    output logic                         match_level,
    output logic [CNT_W-1:0]             match_count,
    output logic [$clog2(PAT_W+1)-1:0]   fill
);

    localparam int FILL_W = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    logic [PAT_W-1:0]  pat_q,   pat_d;
    logic [PAT_W-1:0]  mask_q,  mask_d;
    logic              ovl_q,   ovl_d;
    logic [PAT_W-1:0]  hist_q,  hist_d;
    logic [FILL_W-1:0] fill_q,  fill_d;
    logic              match_q, match_d;
    logic              level_q, level_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;

    logic              accept;
    logic              hit;
    logic [PAT_W-1:0]  hist_sh;
    logic [FILL_W-1:0] fill_sh;

    // The oldest history bit is shifted out before every compare, so it is never read.
    logic unused_oldest_bit;
    assign unused_oldest_bit = hist_q[PAT_W-1];

    always_comb begin
        accept  = sample_en & ~load;
        hist_sh = {hist_q[PAT_W-2:0], din};
        fill_sh = (fill_q == FILL_FULL) ? FILL_FULL : fill_q + 1'b1;
        hit     = accept && (fill_sh == FILL_FULL) &&
                  (((~(hist_sh ^ pat_q)) & mask_q) == mask_q);

        pat_d   = pat_q;
        mask_d  = mask_q;
        ovl_d   = ovl_q;
        hist_d  = hist_q;
        fill_d  = fill_q;
        match_d = 1'b0;
        level_d = level_q;
        cnt_d   = cnt_q;

        if (load) begin
            pat_d   = pattern;
            mask_d  = mask;
            ovl_d   = overlap;
            hist_d  = '0;
            fill_d  = '0;
            level_d = 1'b0;
        end else if (accept) begin
            // Non-overlap mode restarts collection after a match.
            if (hit && !ovl_q) begin
                hist_d = '0;
                fill_d = '0;
            end else begin
                hist_d = hist_sh;
                fill_d = fill_sh;
            end
            match_d = hit;
            level_d = hit;
        end

        if (count_clr) begin
            cnt_d = '0;
        end else if (hit && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pat_q   <= '1;
            mask_q  <= '1;
            ovl_q   <= 1'b1;
            hist_q  <= '0;
            fill_q  <= '0;
            match_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            pat_q   <= pat_d;
            mask_q  <= mask_d;
            ovl_q   <= ovl_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            match_q <= match_d;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    assign match       = match_q;
    assign match_level = level_q;
    assign match_count = cnt_q;
    assign fill        = fill_q;

endmodule

// File: tb/tb_seq_pattern_detector.sv
// Self-checking bench for seq_pattern_detector: vector table, directed corner
// sequences and randomized traffic against a queue-based reference model.
module tb_seq_pattern_detector;

    localparam int PAT_W = 3;
    localparam int FW    = $clog2(PAT_W + 1);

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             sample_en = 1'b0;
    logic             din = 1'b0;
    logic [PAT_W-1:0] pattern = '0;
    logic [PAT_W-1:0] mask = '0;
    logic             overlap = 1'b0;
    logic             load = 1'b0;
    logic             count_clr = 1'b0;

    logic             match, match_level, match2, level2;
    logic [7:0]       match_count;
    logic [1:0]       count2;
    logic [FW-1:0]    fill, fill2;

    always #5 clk = ~clk;

    seq_pattern_detector #(.PAT_W(PAT_W), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .sample_en(sample_en), .din(din),
        .pattern(pattern), .mask(mask), .overlap(overlap), .load(load),
        .count_clr(count_clr), .match(match), .match_level(match_level),
        .match_count(match_count), .fill(fill)
    );

    seq_pattern_detector #(.PAT_W(PAT_W), .CNT_W(2)) u_sat (
        .clk(clk), .rst_n(rst_n), .sample_en(sample_en), .din(din),
        .pattern(pattern), .mask(mask), .overlap(overlap), .load(load),
        .count_clr(count_clr), .match(match2), .match_level(level2),
        .match_count(count2), .fill(fill2)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: the accepted bits since the last restart, oldest first.
    logic [PAT_W-1:0] m_pat, m_mask;
    bit               m_ovl;
    bit               m_hist[$];
    int               m_cnt, m_cnt2;
    bit               m_match, m_level;

    function automatic void model_reset();
        m_pat   = '1;
        m_mask  = '1;
        m_ovl   = 1'b1;
        m_hist.delete();
        m_cnt   = 0;
        m_cnt2  = 0;
        m_match = 1'b0;
        m_level = 1'b0;
    endfunction

    function automatic void model_step(bit se, bit d, bit ld, bit clr,
                                       logic [PAT_W-1:0] p, logic [PAT_W-1:0] mk, bit ov);
        bit hit = 1'b0;
        if (ld) begin
            m_pat  = p;
            m_mask = mk;
            m_ovl  = ov;
            m_hist.delete();
            m_match = 1'b0;
            m_level = 1'b0;
        end else if (se) begin
            m_hist.push_back(d);
            if (m_hist.size() > PAT_W) void'(m_hist.pop_front());
            if (m_hist.size() == PAT_W) begin
                hit = 1'b1;
                for (int i = 0; i < PAT_W; i++)
                    if (m_mask[PAT_W-1-i] && (m_hist[i] != m_pat[PAT_W-1-i])) hit = 1'b0;
            end
            m_match = hit;
            m_level = hit;
            if (hit && !m_ovl) m_hist.delete();
        end else begin
            m_match = 1'b0;
        end
        if (clr) begin
            m_cnt  = 0;
            m_cnt2 = 0;
        end else if (hit) begin
            if (m_cnt < 255) m_cnt++;
            if (m_cnt2 < 3) m_cnt2++;
        end
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_model(string tag);
        chk({tag, ".match"}, 32'(match), 32'(m_match));
        chk({tag, ".level"}, 32'(match_level), 32'(m_level));
        chk({tag, ".fill"}, 32'(fill), 32'(m_hist.size()));
        chk({tag, ".count"}, 32'(match_count), 32'(m_cnt));
        chk({tag, ".count2"}, 32'(count2), 32'(m_cnt2));
    endtask

    // Drive one cycle of inputs, let the edge happen, then settle 1 time unit.
    task automatic step(bit se, bit d, bit ld = 1'b0, bit clr = 1'b0);
        sample_en = se;
        din       = d;
        load      = ld;
        count_clr = clr;
        @(posedge clk);
        model_step(se, d, ld, clr, pattern, mask, overlap);
        #1;
    endtask

    task automatic do_load(logic [PAT_W-1:0] p, logic [PAT_W-1:0] mk, bit ov, bit se = 1'b0);
        pattern = p;
        mask    = mk;
        overlap = ov;
        step(se, 1'b1, 1'b1, 1'b0);
    endtask

    typedef struct {
        bit se;
        bit d;
        bit m;
        bit lv;
        int f;
        int c;
        int c2;
    } vec_t;

    vec_t tbl[9];

    initial begin
        // Default function after reset: three consecutive 1s, overlapping.
        tbl[0] = '{1, 1, 0, 0, 1, 0, 0};
        tbl[1] = '{1, 1, 0, 0, 2, 0, 0};
        tbl[2] = '{1, 1, 1, 1, 3, 1, 1};
        tbl[3] = '{1, 1, 1, 1, 3, 2, 2};
        tbl[4] = '{1, 1, 1, 1, 3, 3, 3};
        tbl[5] = '{0, 0, 0, 1, 3, 3, 3};
        tbl[6] = '{1, 1, 1, 1, 3, 4, 3};
        tbl[7] = '{1, 1, 1, 1, 3, 5, 3};
        tbl[8] = '{1, 0, 0, 0, 3, 5, 3};

        model_reset();
        #12;
        chk("rst.match", 32'(match), 0);
        chk("rst.level", 32'(match_level), 0);
        chk("rst.fill", 32'(fill), 0);
        chk("rst.count", 32'(match_count), 0);
        chk("rst.count2", 32'(count2), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            step(tbl[i].se, tbl[i].d);
            chk($sformatf("tbl%0d.match", i), 32'(match), 32'(tbl[i].m));
            chk($sformatf("tbl%0d.level", i), 32'(match_level), 32'(tbl[i].lv));
            chk($sformatf("tbl%0d.fill", i), 32'(fill), 32'(tbl[i].f));
            chk($sformatf("tbl%0d.count", i), 32'(match_count), 32'(tbl[i].c));
            chk($sformatf("tbl%0d.count2", i), 32'(count2), 32'(tbl[i].c2));
        end

        // Non-overlapping 111: matches on samples 3 and 6, fill restarts at 0.
        do_load(3'b111, 3'b111, 1'b0);
        check_model("nov.load");
        chk("nov.load.fill", 32'(fill), 0);
        chk("nov.load.count_kept", 32'(match_count), 5);
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b1);
            check_model($sformatf("nov%0d", i));
            chk($sformatf("nov%0d.match", i), 32'(match), (i == 2 || i == 5) ? 1 : 0);
        end
        chk("nov.fill_after", 32'(fill), 0);
        chk("nov.count", 32'(match_count), 7);

        // Overlapping 101 on 1,0,1,0,1; clear the count in the cycle of the last match.
        do_load(3'b101, 3'b111, 1'b1);
        step(1'b1, 1'b1); check_model("ovl0");
        step(1'b1, 1'b0); check_model("ovl1");
        step(1'b1, 1'b1); check_model("ovl2");
        chk("ovl2.match", 32'(match), 1);
        step(1'b1, 1'b0); check_model("ovl3");
        chk("ovl3.level", 32'(match_level), 0);
        step(1'b1, 1'b1, 1'b0, 1'b1); check_model("ovl4");
        chk("ovl4.match", 32'(match), 1);
        chk("ovl4.clr_count", 32'(match_count), 0);
        chk("ovl4.clr_count2", 32'(count2), 0);

        // Masked compare: only the middle bit matters, fill must still reach PAT_W.
        do_load(3'b010, 3'b010, 1'b1);
        step(1'b1, 1'b1); check_model("msk0");
        step(1'b1, 1'b1); check_model("msk1");
        chk("msk1.match", 32'(match), 0);
        chk("msk1.fill", 32'(fill), 2);
        step(1'b1, 1'b0); check_model("msk2");
        chk("msk2.match", 32'(match), 1);
        do_load(3'b010, 3'b010, 1'b1, 1'b1);
        check_model("ldse");
        chk("ldse.fill", 32'(fill), 0);
        chk("ldse.match", 32'(match), 0);

        // Asynchronous reset mid-stream, between clock edges.
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("arst.match", 32'(match), 0);
        chk("arst.level", 32'(match_level), 0);
        chk("arst.fill", 32'(fill), 0);
        chk("arst.count", 32'(match_count), 0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1);
            check_model($sformatf("post%0d", i));
            chk($sformatf("post%0d.match", i), 32'(match), (i == 2) ? 1 : 0);
        end

        // Random traffic; pattern/mask/overlap wiggle every cycle but only load may capture them.
        for (int n = 0; n < 400; n++) begin
            pattern = PAT_W'($urandom);
            mask    = ($urandom_range(0, 7) == 0) ? '0 : PAT_W'($urandom);
            overlap = 1'($urandom);
            step(($urandom_range(0, 3) != 0), 1'($urandom),
                 ($urandom_range(0, 24) == 0), ($urandom_range(0, 39) == 0));
            check_model($sformatf("rnd%0d", n));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
